keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans a 4x4 active-low matrix keypad, debounces it and presents one decoded 4-bit key code.
//  Sits directly upstream of the command sequencer FSM.
//  Its tvalida/esnumero outputs drive that FSM's tvalida/esnumero inputs.
//  The sequencer uses the codes as follows:
//    A (1010) = start, C (1100) = separator, B (1011) = end, 0-9 = digits.
//  tvalida idles at 4'b1111, which is never a key code, so no sequencer transition can fire spuriously.
// PARAMETERS
//  SCAN_DIV        1000  clock cycles per column slot (>=2)
//  DEBOUNCE_SCANS  4     consecutive identical full scans needed to accept a press or a release (>=1)
// PORTS
//  CLK          in   1  system clock, all logic on posedge
//  Reset        in   1  synchronous, active-high
//  fila         in   4  keypad rows, active-low, asynchronous (pull-ups)
//  columna      out  4  column drive, active-low, exactly one bit low at any time
//  tvalida      out  4  decoded code of the held key; 4'b1111 when no key is accepted
//  esnumero     out  1  high while tvalida holds a digit 0-9
//  tecla_lista  out  1  one-cycle pulse on the cycle tvalida takes a new key code
// BEHAVIOUR
//  Reset values (next posedge with Reset=1):
//    columna=4'b1110, tvalida=4'b1111, esnumero=0, tecla_lista=0.
//    Divider, column index, debounce counter and candidate are cleared; state=ESPERA.
//  Reset wins over every other event, including in the middle of a press.
//  Row input: fila passes through a 2-FF synchroniser before any use.
//  Scan:
//    - Divider counts 0..SCAN_DIV-1; at terminal count the synced rows are sampled for the active column.
//    - Then the column index advances 0->1->2->3->0 (wraps) and columna is rotated.
//    - Four samples make one full scan.
//  Per scan result:
//    - The first active key in scan order is taken: column 0..3, then row 0..3 within a column.
//    - Other simultaneous keys are ignored.
//    - '#' counts as no key.
//  Keymap (row,col):
//    r0 = 1,2,3,A
//    r1 = 4,5,6,B
//    r2 = 7,8,9,C
//    r3 = *(1110), 0, #(none), D(1101)
//  Key codes = face value; A=1010, B=1011, C=1100.
//  FSM, evaluated at the end of each full scan:
//    ESPERA:
//      - A key is found -> candidate=key, count=1 -> REBOTE.
//      - If DEBOUNCE_SCANS==1, accept immediately (as in REBOTE).
//    REBOTE:
//      - Same key found: count++.
//      - When count reaches DEBOUNCE_SCANS -> accept:
//        - tvalida=code, esnumero=(code<=9), tecla_lista=1 for one cycle -> PULSADA.
//      - Different key or no key -> ESPERA, no output change.
//    PULSADA:
//      - The accepted key is still found, or any other key is found: stay.
//        No new key is accepted until a full release.
//      - No key found: count=1 -> SOLTANDO.
//    SOLTANDO:
//      - No key: count++.
//      - When count reaches DEBOUNCE_SCANS: tvalida=1111, esnumero=0 -> ESPERA.
//      - Any key seen: return to PULSADA with tvalida unchanged.
//  Latency:
//    - Outputs update the cycle after the scan that completes debounce.
//    - Press-to-output is between DEBOUNCE_SCANS and DEBOUNCE_SCANS+1 scans of 4*SCAN_DIV cycles, plus 2 sync cycles.
//  tvalida and esnumero hold stable for the whole PULSADA/SOLTANDO interval.
//  The downstream FSM may therefore sample them at level.
//  tecla_lista never fires twice for one physical press.
// STRUCTURE
//  keypad_pkg: localparams for the codes and the FSM state encoding.
//    TECLA_NINGUNA=4'hF, TECLA_INICIO=4'hA, TECLA_FIN=4'hB, TECLA_SEP=4'hC, TECLA_D=4'hD, TECLA_AST=4'hE.
//  Sub-module sync_2ff (4-bit, CLK/Reset, reset value 4'b1111) synchronises fila.
//  Divider, scan accumulator, debounce counter and FSM stay in this module.
//  The keymap is a combinational case.
// TESTING
//  Bench uses SCAN_DIV=4, DEBOUNCE_SCANS=3; the keypad model pulls fila low when the matching column is driven low.
//  1 Reset held 3 cycles with a key pressed -> columna=1110, tvalida=1111, esnumero=0, tecla_lista=0.
//    No acceptance until 3 scans after release of Reset.
//  2 Hold '5' (r1,c1) for 10 scans -> tvalida=0101, esnumero=1, one tecla_lista pulse.
//    Release -> tvalida=1111 after 3 idle scans.
//  3 Hold 'C' (r2,c3) -> tvalida=1100, esnumero=0.
//    Sequence A,7,C,3,C,1,C,0,C,B,C drives the downstream FSM back to its initial state.
//  4 Bounce '8' for 2 scans, then release -> no tecla_lista, tvalida stays 1111.
//    Glitch a 1-scan release while '8' is held -> no second pulse.
//  5 Press '1' and '9' together -> tvalida=0001.
//    While '1' is held, press '4' -> no change.
//    Press '#' alone -> tvalida stays 1111.
//  6 Assert Reset mid-PULSADA with '2' held -> outputs return to reset values next cycle.
//    '2' is re-accepted after 3 scans with one new pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared key codes, debounce FSM state encoding and the 4x4 keymap lookup
// used by the keypad scanner.
package keypad_pkg;

  localparam logic [3:0] TECLA_NINGUNA = 4'hF;
  localparam logic [3:0] TECLA_INICIO  = 4'hA;
  localparam logic [3:0] TECLA_FIN     = 4'hB;
  localparam logic [3:0] TECLA_SEP     = 4'hC;
  localparam logic [3:0] TECLA_D       = 4'hD;
  localparam logic [3:0] TECLA_AST     = 4'hE;

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    REBOTE   = 2'd1,
    PULSADA  = 2'd2,
    SOLTANDO = 2'd3
  } estado_t;

  // '#' maps to TECLA_NINGUNA so it can never be taken as a key.
  function automatic logic [3:0] tecla_de(input logic [1:0] fila_idx,
                                          input logic [1:0] col_idx);
    logic [3:0] code;
    case ({fila_idx, col_idx})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = TECLA_INICIO;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = TECLA_FIN;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = TECLA_SEP;
      4'b11_00: code = TECLA_AST;
      4'b11_01: code = 4'h0;
      4'b11_10: code = TECLA_NINGUNA;
      default:  code = TECLA_D;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for the asynchronous, active-low keypad rows.
// Resets to all-ones so an idle keypad is seen while the chain refills.
module sync_2ff (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      meta <= 4'b1111;
      q    <= 4'b1111;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column rotation, per-scan key pick,
// debounce FSM and registered code outputs for the command sequencer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] fila,
  output logic [3:0] columna,
  output logic [3:0] tvalida,
  output logic       esnumero,
  output logic       tecla_lista
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  logic [3:0]       fila_s;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_q;
  logic             acc_hit;
  logic [3:0]       acc_key;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       cand_q;
  estado_t          estado;

  logic             col_hit;
  logic [3:0]       col_key;
  logic             slot_end;
  logic             scan_end;
  logic             scan_hit;
  logic [3:0]       scan_key;

  sync_2ff u_sync (
    .CLK   (CLK),
    .Reset (Reset),
    .d     (fila),
    .q     (fila_s)
  );

  // Lowest active row of the current column wins; '#' alone is ignored.
  always_comb begin
    col_hit = 1'b0;
    col_key = TECLA_NINGUNA;
    for (int r = 3; r >= 0; r--) begin
      if (!fila_s[r] && tecla_de(2'(r), col_q) != TECLA_NINGUNA) begin
        col_hit = 1'b1;
        col_key = tecla_de(2'(r), col_q);
      end
    end
  end

  assign slot_end = (div_q == DIV_LAST);
  assign scan_end = slot_end && (col_q == 2'd3);
  assign scan_hit = acc_hit | col_hit;
  assign scan_key = acc_hit ? acc_key : col_key;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      div_q   <= '0;
      col_q   <= 2'd0;
      columna <= 4'b1110;
      acc_hit <= 1'b0;
      acc_key <= TECLA_NINGUNA;
    end else if (slot_end) begin
      div_q   <= '0;
      col_q   <= col_q + 2'd1;
      columna <= {columna[2:0], columna[3]};
      if (scan_end) begin
        acc_hit <= 1'b0;
        acc_key <= TECLA_NINGUNA;
      end else begin
        acc_hit <= scan_hit;
        acc_key <= scan_key;
      end
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Debounce FSM: only advances on the cycle that closes a full scan.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      estado      <= ESPERA;
      cnt_q       <= '0;
      cand_q      <= TECLA_NINGUNA;
      tvalida     <= TECLA_NINGUNA;
      esnumero    <= 1'b0;
      tecla_lista <= 1'b0;
    end else begin
      tecla_lista <= 1'b0;
      if (scan_end) begin
        case (estado)
          ESPERA: begin
            if (scan_hit) begin
              cand_q <= scan_key;
              cnt_q  <= CNT_W'(1);
              if (DEBOUNCE_SCANS == 1) begin
                tvalida     <= scan_key;
                esnumero    <= (scan_key <= 4'd9);
                tecla_lista <= 1'b1;
                estado      <= PULSADA;
              end else begin
                estado <= REBOTE;
              end
            end
          end
          REBOTE: begin
            if (scan_hit && scan_key == cand_q) begin
              if (cnt_q == CNT_LAST) begin
                tvalida     <= cand_q;
                esnumero    <= (cand_q <= 4'd9);
                tecla_lista <= 1'b1;
                estado      <= PULSADA;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end else begin
              estado <= ESPERA;
            end
          end
          PULSADA: begin
            if (!scan_hit) begin
              cnt_q <= CNT_W'(1);
              if (DEBOUNCE_SCANS == 1) begin
                tvalida  <= TECLA_NINGUNA;
                esnumero <= 1'b0;
                estado   <= ESPERA;
              end else begin
                estado <= SOLTANDO;
              end
            end
          end
          SOLTANDO: begin
            if (scan_hit) begin
              estado <= PULSADA;
            end else if (cnt_q == CNT_LAST) begin
              tvalida  <= TECLA_NINGUNA;
              esnumero <= 1'b0;
              estado   <= ESPERA;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: estado <= ESPERA;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model drives fila, a per-scan
// reference model queues expected output events, a monitor pops and compares.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DS       = 3;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] fila;
  logic [3:0] columna;
  logic [3:0] tvalida;
  logic       esnumero;
  logic       tecla_lista;

  logic [15:0] pressed = 16'h0000;   // bit r*4+c = key at row r, column c
  logic        mon_en = 1'b0;

  typedef struct packed {
    logic [3:0] code;
    logic       num;
    logic       pulse;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  n_pulses = 0;
  int  m_accepts = 0;

  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  logic [3:0] m_held = 4'hF;
  logic [3:0] m_cand = 4'hF;
  int         m_run = 0;

  always #5 CLK = ~CLK;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DS)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .fila        (fila),
    .columna     (columna),
    .tvalida     (tvalida),
    .esnumero    (esnumero),
    .tecla_lista (tecla_lista)
  );

  always_comb begin
    fila = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !columna[c]) fila[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] kb(input logic [3:0] code);
    for (int i = 0; i < 16; i++)
      if (keymap[i] == code) return 16'(1) << i;
    return 16'h0000;
  endfunction

  // Winning key of one full scan: column-major, '#' never counts.
  function automatic logic [3:0] scan_result(input logic [15:0] p);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (p[r*4+c] && keymap[r*4+c] != 4'hF) return keymap[r*4+c];
    return 4'hF;
  endfunction

  task automatic model_scan(input logic [15:0] p);
    logic [3:0] k;
    k = scan_result(p);
    if (m_held == 4'hF) begin
      if (m_run > 0) begin
        if (k == m_cand) m_run++;
        else m_run = 0;
      end else if (k != 4'hF) begin
        m_cand = k;
        m_run = 1;
      end
      if (m_run == DS) begin
        exp_q.push_back('{code: m_cand, num: (m_cand <= 4'd9), pulse: 1'b1});
        m_accepts++;
        m_held = m_cand;
        m_run = 0;
      end
    end else begin
      if (k == 4'hF) begin
        m_run++;
        if (m_run == DS) begin
          exp_q.push_back('{code: 4'hF, num: 1'b0, pulse: 1'b0});
          m_held = 4'hF;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic next_scan();
    logic [3:0] prev;
    int n;
    prev = columna;
    n = 0;
    forever begin
      @(negedge CLK);
      if (prev == 4'b0111 && columna == 4'b1110) break;
      prev = columna;
      n++;
      if (n > 8 * SCAN_DIV) begin
        n_checks++;
        n_fail++;
        $display("FAIL scan_timeout: columna stuck at %b", columna);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "scan never completed");
      end
    end
  endtask

  task automatic run_scans(input logic [15:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      pressed = p;
      model_scan(p);
      next_scan();
    end
  endtask

  task automatic do_reset(input int cycles);
    if (m_held != 4'hF) exp_q.push_back('{code: 4'hF, num: 1'b0, pulse: 1'b0});
    m_held = 4'hF;
    m_run = 0;
    Reset = 1'b1;
    repeat (cycles) @(negedge CLK);
    chk("rst_columna", 32'(columna), 32'h000E);
    chk("rst_tvalida", 32'(tvalida), 32'h000F);
    chk("rst_esnumero", 32'(esnumero), 32'h0);
    chk("rst_tecla_lista", 32'(tecla_lista), 32'h0);
    Reset = 1'b0;
  endtask

  // Monitor: every output change or pulse is an event to match.
  initial begin
    logic [3:0] prev_tv;
    logic       prev_es;
    logic       prev_p;
    ev_t        e;
    wait (mon_en);
    prev_tv = tvalida;
    prev_es = esnumero;
    prev_p  = 1'b0;
    forever begin
      @(negedge CLK);
      chk("columna_one_low",
          32'(columna inside {4'b1110, 4'b1101, 4'b1011, 4'b0111}), 32'h1);
      if (prev_p) chk("pulse_width", 32'(tecla_lista), 32'h0);
      if (tecla_lista) n_pulses++;
      if (tecla_lista || tvalida != prev_tv || esnumero != prev_es) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_event: got tvalida=%h esnumero=%b tecla_lista=%b, expected no change",
                   tvalida, esnumero, tecla_lista);
        end else begin
          e = exp_q.pop_front();
          chk("event", 32'({tvalida, esnumero, tecla_lista}), 32'({e.code, e.num, e.pulse}));
        end
      end
      prev_tv = tvalida;
      prev_es = esnumero;
      prev_p  = tecla_lista;
    end
  end

  initial begin
    logic [3:0] seq [11];
    logic [15:0] p;
    int sel;
    seq = '{4'hA, 4'h7, 4'hC, 4'h3, 4'hC, 4'h1, 4'hC, 4'h0, 4'hC, 4'hB, 4'hC};

    // Reset with '5' already held, then hold and release it
    pressed = kb(4'h5);
    do_reset(3);
    mon_en = 1'b1;
    run_scans(kb(4'h5), 10);
    run_scans(16'h0, 5);

    // Sequencer command sequence
    for (int i = 0; i < 11; i++) begin
      run_scans(kb(seq[i]), 4);
      run_scans(16'h0, 4);
    end

    // Bounces and release glitch on '8'
    run_scans(kb(4'h8), 2);
    run_scans(16'h0, 4);
    run_scans(kb(4'h8), 5);
    run_scans(16'h0, 1);
    run_scans(kb(4'h8), 5);
    run_scans(16'h0, 4);

    // Simultaneous keys, lockout while held, '#'
    run_scans(kb(4'h1) | kb(4'h9), 4);
    run_scans(kb(4'h1) | kb(4'h4), 3);
    run_scans(kb(4'h1), 2);
    run_scans(16'h0, 4);
    run_scans(kb(4'hF), 5);
    run_scans(16'h0, 2);

    // Reset in the middle of a held '2'
    run_scans(kb(4'h2), 6);
    do_reset(2);
    run_scans(kb(4'h2), 5);
    run_scans(16'h0, 4);

    // Randomised hold patterns
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) p = 16'h0;
      else if (sel < 8) p = 16'(1) << $urandom_range(0, 15);
      else p = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      run_scans(p, $urandom_range(1, 6));
    end

    run_scans(16'h0, 5);
    repeat (4) @(negedge CLK);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    chk("pulse_count", 32'(n_pulses), 32'(m_accepts));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
